exp_cordic: RTL and testbench

Fixed-point exponential unit: computes RESULT = e^T for a signed fixed-point argument T. It uses range reduction T = k·ln2 + r, then hyperbolic CORDIC in rotation mode on r, then a 2^k shift. It is the inverse companion of the CORDIC natural-log linearizer and shares the same Begin/ACK handshake and O_F/U_F flag semantics. It is used wherever a linearized (log-domain) value must be converted back to the linear domain.

---
 rtl/exp_cordic.sv | 208 ++++++++++++++++++++
 tb/tb_exp_cordic.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/exp_cordic.sv
// Fixed-point e^T: range reduction T = k*ln2 + r, hyperbolic CORDIC rotation on r,
// then a 2^k shift with saturation/underflow flags. Begin/ACK level handshake.
module exp_cordic #(
    parameter int P    = 32,
    parameter int FRAC = 24,
    parameter int ITER = 16
) (
    input  logic         CLK,
    input  logic         RST_EXP_N,
    input  logic         RST_FSM_EXP,
    input  logic         Begin_FSM_EXP,
    input  logic [P-1:0] T,
    output logic         ACK_EXP,
    output logic         O_F,
    output logic         U_F,
    output logic [P-1:0] RESULT,
    output logic [3:0]   dbg_state_o
);

    localparam int W  = P + 2;
    localparam int KW = 12;
    localparam int IW = $clog2(ITER + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_RED1, S_RED2, S_INIT, S_ROT, S_SUM, S_SCALE, S_DONE
    } state_t;

    function automatic real frac_scale();
        real s;
        s = 1.0;
        for (int j = 0; j < FRAC; j++) s = s * 2.0;
        return s;
    endfunction

    function automatic logic [W-1:0] to_fixed(input real v);
        return W'($rtoi(v * frac_scale() + 0.5));
    endfunction

    function automatic logic [ITER:1][W-1:0] build_atanh_rom();
        logic [ITER:1][W-1:0] rom;
        real                  x;
        rom = '0;
        x   = 1.0;
        for (int i = 1; i <= ITER; i++) begin
            x      = x / 2.0;
            rom[i] = to_fixed(0.5 * $ln((1.0 + x) / (1.0 - x)));
        end
        return rom;
    endfunction

    localparam logic [W-1:0]            INV_LN2_C = to_fixed(1.4426950409);
    localparam logic [W-1:0]            LN2_C     = to_fixed(0.6931471806);
    localparam logic [W-1:0]            X0_C      = to_fixed(1.2074970677);
    localparam logic [ITER:1][W-1:0]    ATANH_ROM = build_atanh_rom();
    localparam logic signed [KW-1:0]    K_OVF     = KW'(P - FRAC - 1);
    localparam logic signed [KW-1:0]    K_UNF     = KW'(-FRAC);

    state_t                 state_q, state_d;
    logic [P-1:0]           t_q, t_d;
    logic signed [KW-1:0]   k_q, k_d;
    logic signed [W-1:0]    r_q, r_d;
    logic signed [W-1:0]    x_q, x_d;
    logic signed [W-1:0]    y_q, y_d;
    logic signed [W-1:0]    z_q, z_d;
    logic signed [W-1:0]    e_q, e_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   rep_q, rep_d;
    logic [P-1:0]           result_q, result_d;
    logic                   of_q, of_d;
    logic                   uf_q, uf_d;

    logic [2*P+1:0]         prod;
    logic [W-1:0]           k_ln2;
    logic [KW-1:0]          neg_k;
    logic signed [W-1:0]    x_sh, y_sh, atanh_i;
    logic                   need_rep;

    assign prod    = {{(P+2){t_q[P-1]}}, t_q} * {{P{1'b0}}, INV_LN2_C};
    assign k_ln2   = {{(W-KW){k_q[KW-1]}}, k_q} * LN2_C;
    assign neg_k   = -k_q;
    assign x_sh    = x_q >>> idx_q;
    assign y_sh    = y_q >>> idx_q;
    assign atanh_i = $signed(ATANH_ROM[idx_q]);
    // Indices 4 and 13 are run twice so the hyperbolic rotation converges.
    assign need_rep = ((idx_q == IW'(4)) || ((ITER >= 13) && (idx_q == IW'(13)))) && !rep_q;

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        k_d      = k_q;
        r_d      = r_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        e_d      = e_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        result_d = result_q;
        of_d     = of_q;
        uf_d     = uf_q;
        if (RST_FSM_EXP) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (Begin_FSM_EXP) state_d = S_LOAD;
                S_LOAD: begin
                    t_d     = T;
                    state_d = S_RED1;
                end
                S_RED1: begin
                    k_d     = KW'($signed(prod) >>> (2 * FRAC));
                    state_d = S_RED2;
                end
                S_RED2: begin
                    r_d     = $signed({{2{t_q[P-1]}}, t_q}) - $signed(k_ln2);
                    state_d = S_INIT;
                end
                S_INIT: begin
                    x_d     = $signed(X0_C);
                    y_d     = '0;
                    z_d     = r_q;
                    idx_d   = IW'(1);
                    rep_d   = 1'b0;
                    state_d = S_ROT;
                end
                S_ROT: begin
                    if (!z_q[W-1]) begin
                        x_d = x_q + y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atanh_i;
                    end else begin
                        x_d = x_q - y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atanh_i;
                    end
                    if (need_rep) begin
                        rep_d = 1'b1;
                    end else begin
                        rep_d = 1'b0;
                        idx_d = idx_q + IW'(1);
                        if (idx_q == IW'(ITER)) state_d = S_SUM;
                    end
                end
                S_SUM: begin
                    e_d     = x_q + y_q;
                    state_d = S_SCALE;
                end
                S_SCALE: begin
                    of_d = 1'b0;
                    uf_d = 1'b0;
                    if (k_q >= K_OVF) begin
                        of_d     = 1'b1;
                        result_d = {1'b0, {(P-1){1'b1}}};
                    end else if (k_q < K_UNF) begin
                        uf_d     = 1'b1;
                        result_d = '0;
                    end else if (!k_q[KW-1]) begin
                        result_d = P'(e_q <<< k_q);
                    end else begin
                        result_d = P'(e_q >>> neg_k);
                    end
                    state_d = S_DONE;
                end
                S_DONE: if (!Begin_FSM_EXP) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_EXP_N) begin
        if (!RST_EXP_N) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            k_q      <= '0;
            r_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            e_q      <= '0;
            idx_q    <= '0;
            rep_q    <= 1'b0;
            result_q <= '0;
            of_q     <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            k_q      <= k_d;
            r_q      <= r_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            e_q      <= e_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            result_q <= result_d;
            of_q     <= of_d;
            uf_q     <= uf_d;
        end
    end

    assign ACK_EXP     = (state_q == S_DONE);
    assign O_F         = of_q;
    assign U_F         = uf_q;
    assign RESULT      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_exp_cordic.sv
// Bench for exp_cordic: directed handshake/reset/flag cases plus random arguments
// checked against a real-valued e^T model with the defined k selection rule.
module tb_exp_cordic;

    localparam longint LO_RAW = 64'd436207616;   // 26.0 in Q8.24
    localparam longint SPAN   = 64'd516738252;   // 26.0 + 4.8 in Q8.24

    logic        CLK = 1'b0;
    logic        RST_EXP_N;
    logic        RST_FSM_EXP;
    logic        Begin_FSM_EXP;
    logic [31:0] T;
    logic        ACK_EXP;
    logic        O_F;
    logic        U_F;
    logic [31:0] RESULT;
    logic [3:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    longint      tol_q[$];
    logic [1:0]  flag_q[$];

    exp_cordic dut (
        .CLK           (CLK),
        .RST_EXP_N     (RST_EXP_N),
        .RST_FSM_EXP   (RST_FSM_EXP),
        .Begin_FSM_EXP (Begin_FSM_EXP),
        .T             (T),
        .ACK_EXP       (ACK_EXP),
        .O_F           (O_F),
        .U_F           (U_F),
        .RESULT        (RESULT),
        .dbg_state_o   (dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
        total++;
        if ((obs > exp + tol) || (obs < exp - tol)) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // e^T from real arithmetic; k decides the flags exactly as the block defines it.
    task automatic model(input logic [31:0] t, output longint e, output longint tol,
                         output bit of, output bit uf);
        longint prod;
        longint k;
        real    v;
        prod = longint'($signed(t)) * 64'sd24204406;
        k    = prod >>> 48;
        of   = 1'b0;
        uf   = 1'b0;
        tol  = 0;
        if (k >= 7) begin
            of = 1'b1;
            e  = 64'h7FFFFFFF;
        end else if (k < -24) begin
            uf = 1'b1;
            e  = 0;
        end else begin
            v   = $exp(real'($signed(t)) / 16777216.0) * 16777216.0;
            e   = longint'(v);
            tol = e / 8192 + 4;
        end
    endtask

    // Called on a negedge; raises Begin immediately and leaves on a negedge with Begin low.
    task automatic run_one(input string tag, input logic [31:0] t, input longint e,
                           input longint tol, input bit of, input bit uf, input int hold);
        int          cyc;
        int          lows;
        bit          got;
        logic [31:0] ev;
        longint      et;
        logic [1:0]  ef;
        T             = t;
        Begin_FSM_EXP = 1'b1;
        exp_q.push_back(e[31:0]);
        tol_q.push_back(tol);
        flag_q.push_back({of, uf});
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            got = ACK_EXP;
        end
        ev = exp_q.pop_front();
        et = tol_q.pop_front();
        ef = flag_q.pop_front();
        check({tag, ".ack"}, longint'(got), 1, 0);
        check({tag, ".lat"}, longint'(cyc), 25, 0);
        check({tag, ".res"}, longint'(RESULT), longint'(ev), et);
        check({tag, ".of"}, longint'(O_F), longint'(ef[1]), 0);
        check({tag, ".uf"}, longint'(U_F), longint'(ef[0]), 0);
        if (hold > 0) begin
            lows = 0;
            repeat (hold) begin
                @(negedge CLK);
                if (!ACK_EXP) lows++;
            end
            check({tag, ".hold_ack_lows"}, longint'(lows), 0, 0);
            check({tag, ".hold_res"}, longint'(RESULT), longint'(ev), et);
        end
        Begin_FSM_EXP = 1'b0;
        @(negedge CLK);
        check({tag, ".ack_drop"}, longint'(ACK_EXP), 0, 0);
    endtask

    initial begin
        logic [31:0] t;
        longint      e;
        longint      tol;
        bit          of;
        bit          uf;
        int          highs;

        RST_EXP_N     = 1'b0;
        RST_FSM_EXP   = 1'b0;
        Begin_FSM_EXP = 1'b0;
        T             = '0;
        repeat (3) @(negedge CLK);
        check("rst.ack", longint'(ACK_EXP), 0, 0);
        check("rst.res", longint'(RESULT), 0, 0);
        check("rst.of", longint'(O_F), 0, 0);
        check("rst.uf", longint'(U_F), 0, 0);
        RST_EXP_N = 1'b1;
        @(negedge CLK);

        run_one("t0", 32'h00000000, 64'h01000000, 64'h400, 1'b0, 1'b0, 0);
        run_one("t1", 32'h01000000, 64'h02B7E151, 64'hB00, 1'b0, 1'b0, 0);
        run_one("tm2", 32'hFE000000, 64'h0022A574, 64'h100, 1'b0, 1'b0, 0);

        // Asynchronous reset while rotating.
        T             = 32'h01000000;
        Begin_FSM_EXP = 1'b1;
        repeat (10) @(negedge CLK);
        Begin_FSM_EXP = 1'b0;
        RST_EXP_N     = 1'b0;
        #1;
        check("arst.ack", longint'(ACK_EXP), 0, 0);
        check("arst.res", longint'(RESULT), 0, 0);
        check("arst.of", longint'(O_F), 0, 0);
        check("arst.uf", longint'(U_F), 0, 0);
        @(negedge CLK);
        RST_EXP_N = 1'b1;
        @(negedge CLK);
        run_one("after_arst", 32'h00000000, 64'h01000000, 64'h400, 1'b0, 1'b0, 0);

        run_one("ovf5", 32'h05000000, 64'h7FFFFFFF, 0, 1'b1, 1'b0, 0);

        // Soft reset while rotating keeps the previous (saturated) result.
        T             = 32'hFE000000;
        Begin_FSM_EXP = 1'b1;
        repeat (10) @(negedge CLK);
        Begin_FSM_EXP = 1'b0;
        RST_FSM_EXP   = 1'b1;
        @(negedge CLK);
        RST_FSM_EXP = 1'b0;
        check("srst.ack", longint'(ACK_EXP), 0, 0);
        check("srst.res", longint'(RESULT), 64'h7FFFFFFF, 0);
        check("srst.of", longint'(O_F), 1, 0);
        highs = 0;
        repeat (30) begin
            @(negedge CLK);
            if (ACK_EXP) highs++;
        end
        check("srst.no_ack", longint'(highs), 0, 0);

        // Soft reset together with Begin must not start anything.
        RST_FSM_EXP   = 1'b1;
        Begin_FSM_EXP = 1'b1;
        T             = 32'h00000000;
        @(negedge CLK);
        RST_FSM_EXP   = 1'b0;
        Begin_FSM_EXP = 1'b0;
        highs = 0;
        repeat (30) begin
            @(negedge CLK);
            if (ACK_EXP) highs++;
        end
        check("srst_begin.no_ack", longint'(highs), 0, 0);
        check("srst_begin.res", longint'(RESULT), 64'h7FFFFFFF, 0);

        run_one("unf20", 32'hEC000000, 0, 0, 1'b0, 1'b1, 0);
        run_one("tmin", 32'h80000000, 0, 0, 1'b0, 1'b1, 0);
        run_one("tmax", 32'h7FFFFFFF, 64'h7FFFFFFF, 0, 1'b1, 1'b0, 0);

        // Begin held for 40 cycles, then an immediate restart with a new argument.
        run_one("hold", 32'h01000000, 64'h02B7E151, 64'hB00, 1'b0, 1'b0, 15);
        run_one("rehold", 32'hFE000000, 64'h0022A574, 64'h100, 1'b0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            t = 32'($urandom_range(32'(SPAN), 0)) - 32'(LO_RAW);
            model(t, e, tol, of, uf);
            run_one($sformatf("rnd%0d_%08h", i, t), t, e, tol, of, uf, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
